cmp_share_arbiter: RTL and testbench
====================================

# cmp_share_arbiter

Round-robin arbiter and sequencer that shares one 3-bit magnitude comparator among NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle and compares its pair. It returns a registered greater/equal/smaller result tagged with the requester index, and it holds that result under downstream backpressure. It sits between the operand-producing units and the single comparator instance, so several clients can use one comparator without contention logic of their own.

## Interface
- NREQ, 4: number of requesters (2..8).
- W, 3: operand width in bits.
- IDW, $clog2(NREQ): width of the response ID.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot grant. A transfer occurs when req_valid[i] && req_ready[i].
- rsp_valid  out  1  a result is held in the output register.
- rsp_ready  in  1  downstream accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_gt  out  1  A > B (unsigned).
- rsp_eq  out  1  A == B.
- rsp_lt  out  1  A < B.
- cmp_count  out  16  number of completed responses; saturates at 16'hFFFF.

## Operation
- Output register (slot) states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- slot_free = !rsp_valid || rsp_ready. Grants are issued only when slot_free=1.
- Arbitration (combinational):
  - Search starts at last_grant+1 mod NREQ and scans upward with wrap.
  - The first requester with req_valid=1 receives req_ready=1.
  - At most one req_ready bit is high. All are 0 when slot_free=0 or no request is pending.
- req_ready[i] does not depend on req_b or req_a, only on req_valid, the pointer and the slot state.
- On a transfer to requester g:
  - The comparator evaluates req_a[g], req_b[g].
  - The slot loads {id=g, gt, eq, lt}.
  - rsp_valid is set to 1.
  - last_grant is set to g.
- Slot transitions:
  - Drain without a new transfer (rsp_valid && rsp_ready, no grant): rsp_valid goes to 0. Payload outputs hold their last value.
  - Drain and transfer in the same cycle: the new result replaces the old one and rsp_valid stays 1, giving back-to-back throughput of 1 per cycle.
  - FULL with rsp_ready=0: slot, payload and last_grant hold. All req_ready bits are 0.
- Flags are one-hot: exactly one of gt/eq/lt is set whenever rsp_valid=1.
- Comparison is unsigned, W bits, with no extension.
- cmp_count increments on each completed response (rsp_valid && rsp_ready) and stops at 16'hFFFF.
- Requesters may drop req_valid without a transfer; the arbiter takes no action.
- Fairness: a continuously valid requester is granted within NREQ grant cycles.

## Timing
- Latency: a transfer in cycle N presents its result (rsp_valid=1) in cycle N+1.
- Throughput: 1 compare per cycle while rsp_ready=1.
- Reset values, applied on the first rising edge with rst=1:
  - rsp_valid=0, rsp_id=0, rsp_gt=0, rsp_eq=0, rsp_lt=0.
  - cmp_count=0.
  - last_grant=NREQ-1, so requester 0 has top priority first.
  - req_ready is all zero while rst=1.
- Reset mid-operation: a pending result is discarded with no response and no count. Requests presented during the reset cycle are not transferred.
- Simultaneous requests from all requesters: grants rotate 0,1,2,3,0… with one per cycle.
- Wrap-around: with last_grant=NREQ-1, the search restarts at index 0.

## Structure
- Shared package cmp_share_pkg holds:
  - typedef cmp_rsp_t, a packed struct {id, gt, eq, lt}.
  - Localparams for the default NREQ and W.
- Sub-module mag_cmp_w: a purely combinational W-bit unsigned comparator with a, b inputs and gt, eq, lt outputs. Instantiate it once.
- The top level contains the rotate-priority arbiter, the slot register, last_grant and cmp_count.

## Test plan
- Reset with rst=1 for 2 cycles, all req_valid=1. Required: req_ready=0000 and rsp_valid=0. After release, the first grant goes to requester 0.
- Single requester 2 with a=3'b110, b=3'b001. Required: req_ready=0100 in cycle N, then in N+1 rsp_valid=1, rsp_id=2, gt=1, eq=0, lt=0.
- All four valid with pairs (010,011), (101,100), (111,111), (000,000) and rsp_ready=1. Required: ids 0,1,2,3 on consecutive cycles with flags lt, gt, eq, eq, and cmp_count=4.
- Backpressure: hold rsp_ready=0 for 3 cycles after the first result. Required: rsp_* stable, req_ready=0000. When rsp_ready rises, the next grant happens in that same cycle.
- Wrap and fairness: requesters 3 and 0 continuously valid, starting from last_grant=2. Required: grant order 3,0,3,0.
- Mid-operation reset: assert rst while rsp_valid=1 and rsp_ready=0. Required: next cycle rsp_valid=0 and cmp_count=0; no response for the discarded result.

Source files
------------

// File: rtl/cmp_share_pkg.sv
// cmp_share_pkg: shared types and defaults for the shared-comparator arbiter
package cmp_share_pkg;
   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 3;
   localparam int ID_MAXW  = 3;
   typedef enum logic {EMPTY, FULL} slot_st_t;
   typedef struct packed {
      logic [ID_MAXW-1:0] id;
      logic               gt;
      logic               eq;
      logic               lt;
   } cmp_rsp_t;
endpackage

// File: rtl/mag_cmp_w.sv
// mag_cmp_w: combinational W-bit unsigned magnitude comparator
module mag_cmp_w #(
   parameter int W = 3
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic         eq,
   output logic         lt
);
   assign gt = a > b;
   assign eq = a == b;
   assign lt = a < b;
endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one comparator among NREQ requesters
module cmp_share_arbiter
   import cmp_share_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_gt,
   output logic              rsp_eq,
   output logic              rsp_lt,
   output logic [15:0]       cmp_count
);
   slot_st_t       st, st_nxt;
   cmp_rsp_t       slot;
   logic [IDW-1:0] last_grant, gnt_idx;
   logic           gnt_any, slot_free, xfer, drain;
   logic [W-1:0]   a_sel, b_sel;
   logic           gt, eq, lt;
   logic [15:0]    cnt;
   // Scan from highest to lowest offset so the entry just after last_grant wins
   always_comb begin
      int j;
      j       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = int'(last_grant) + k;
         j = (j >= NREQ) ? j - NREQ : j;
         if (req_valid[IDW'(j)]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'(j);
         end
      end
   end
   assign slot_free = (st == EMPTY) || rsp_ready;
   assign req_ready = (!rst && slot_free && gnt_any) ? NREQ'(1) << gnt_idx : '0;
   assign xfer      = |req_ready;
   assign drain     = (st == FULL) && rsp_ready;
   assign a_sel     = req_a[gnt_idx*W +: W];
   assign b_sel     = req_b[gnt_idx*W +: W];
   mag_cmp_w #(.W(W)) u_cmp (
      .a (a_sel),
      .b (b_sel),
      .gt(gt),
      .eq(eq),
      .lt(lt)
   );
   always_ff @(posedge clk) begin
      if (rst) st <= EMPTY;
      else     st <= st_nxt;
   end
   always_comb begin
      st_nxt = xfer ? FULL : drain ? EMPTY : st;
   end
   always_comb begin
      rsp_valid = st == FULL;
      rsp_id    = IDW'(slot.id);
      rsp_gt    = slot.gt;
      rsp_eq    = slot.eq;
      rsp_lt    = slot.lt;
      cmp_count = cnt;
   end
   // Payload only moves on a transfer, so it holds through drains and backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         slot       <= '0;
         last_grant <= IDW'(NREQ - 1);
         cnt        <= '0;
      end else begin
         if (xfer) begin
            slot       <= '{id: ID_MAXW'(gnt_idx), gt: gt, eq: eq, lt: lt};
            last_grant <= gnt_idx;
         end
         if (drain && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: scoreboard bench for the shared-comparator arbiter
module tb_cmp_share_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [11:0] req_a = '0;
   logic [11:0] req_b = '0;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic        rsp_gt, rsp_eq, rsp_lt;
   logic [15:0] cmp_count;
   int          n_chk = 0;
   int          n_err = 0;
   logic [4:0]  q[$];
   logic        m_valid = 1'b0;
   int          m_last = 3;
   logic [15:0] m_cnt = '0;
   localparam logic [11:0] PA = {3'b000, 3'b111, 3'b101, 3'b010};
   localparam logic [11:0] PB = {3'b000, 3'b111, 3'b100, 3'b011};
   always #5 clk = ~clk;
   cmp_share_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_gt   (rsp_gt),
      .rsp_eq   (rsp_eq),
      .rsp_lt   (rsp_lt),
      .cmp_count(cmp_count)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic cyc(input logic r, input logic [3:0] v, input logic [11:0] a,
                      input logic [11:0] b, input logic rr);
      logic [3:0] er;
      logic [2:0] x, y;
      int g;
      @(negedge clk);
      rst = r; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
      #1;
      er = '0;
      g  = -1;
      if (!r && (!m_valid || rr))
         for (int k = 1; k <= 4; k++)
            if (g < 0 && v[(m_last + k) % 4]) g = (m_last + k) % 4;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid && q.size() > 0) begin
         chk("rsp_id", 32'(rsp_id), 32'(q[0][4:3]));
         chk("rsp_flags", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'(q[0][2:0]));
      end
      chk("cmp_count", 32'(cmp_count), 32'(m_cnt));
      if (r) begin
         m_valid = 1'b0; m_last = 3; m_cnt = '0; q.delete();
      end else begin
         if (m_valid && rr) begin
            void'(q.pop_front());
            m_valid = 1'b0;
            if (m_cnt != 16'hFFFF) m_cnt++;
         end
         if (g >= 0) begin
            x = a[g*3 +: 3];
            y = b[g*3 +: 3];
            q.push_back({2'(g), x > y, x == y, x < y});
            m_valid = 1'b1;
            m_last  = g;
         end
      end
   endtask
   initial begin
      @(posedge clk);
      cyc(1, 4'hF, PA, PB, 1);
      cyc(1, 4'hF, PA, PB, 1);
      @(posedge clk); #1;
      chk("rst_payload", 32'({rsp_id, rsp_gt, rsp_eq, rsp_lt}), 32'd0);
      cyc(0, 4'hF, PA, PB, 1);
      cyc(0, 4'h0, PA, PB, 1);
      cyc(0, 4'b0100, {3'b000, 3'b110, 6'd0}, {3'b000, 3'b001, 6'd0}, 1);
      cyc(0, 4'h0, '0, '0, 1);
      cyc(1, 4'h0, PA, PB, 1);
      for (int i = 0; i < 4; i++) cyc(0, 4'hF, PA, PB, 1);
      cyc(0, 4'h0, PA, PB, 1);
      @(posedge clk); #1;
      chk("count4", 32'(cmp_count), 32'd4);
      cyc(0, 4'hF, PA, PB, 1);
      for (int i = 0; i < 3; i++) cyc(0, 4'hF, PA, PB, 0);
      cyc(0, 4'hF, PA, PB, 1);
      cyc(0, 4'b0100, PA, PB, 1);
      for (int i = 0; i < 4; i++) cyc(0, 4'b1001, PA, PB, 1);
      cyc(0, 4'h0, PA, PB, 1);
      for (int i = 0; i < 80; i++)
         cyc(0, 4'($urandom), 12'($urandom), 12'($urandom), 1'($urandom_range(0, 3) != 0));
      cyc(0, 4'h0, PA, PB, 1);
      cyc(0, 4'hF, PA, PB, 1);
      cyc(0, 4'h0, PA, PB, 0);
      cyc(1, 4'hF, PA, PB, 0);
      cyc(0, 4'h0, PA, PB, 1);
      cyc(0, 4'h0, PA, PB, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
